// File: rtl/tt_addsub_pkg.sv
// rtl/tt_addsub_pkg.sv - shared constants and state type for the serial add/sub block
package tt_addsub_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int START_BIT = 0;
    localparam int MODE_BIT  = 1;
    localparam int FLAG_BIT  = 4;
    localparam int BUSY_BIT  = 5;
    localparam int DONE_BIT  = 6;

endpackage

// File: rtl/serial_addsub_cell.sv
// rtl/serial_addsub_cell.sv - 1-bit full adder / full subtractor cell
module serial_addsub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic d,
    output logic cout
);

    assign d = a ^ b ^ cin;

    // mode=1 turns the carry into a borrow out of a - b - cin
    assign cout = mode ? ((~a & b) | (cin & ~(a ^ b)))
                       : ((a & b)  | (cin & (a ^ b)));

endmodule

// File: rtl/tt_um_serial_addsub.sv
// rtl/tt_um_serial_addsub.sv - bit-serial 4-bit adder/subtractor, Tiny Tapeout wrapper
module tt_um_serial_addsub
    import tt_addsub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   result;
    logic               cy;
    logic               mode_q;
    logic               flag;
    logic               busy;
    logic               done;
    logic               start_q;
    logic               launch;
    logic               bit_d;
    logic               bit_c;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:2]};

    assign launch = uio_in[START_BIT] & ~start_q;

    serial_addsub_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (cy),
        .mode (mode_q),
        .d    (bit_d),
        .cout (bit_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            result  <= '0;
            cy      <= 1'b0;
            mode_q  <= 1'b0;
            flag    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= uio_in[START_BIT];
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        a_sr   <= ui_in[WIDTH-1:0];
                        b_sr   <= ui_in[2*WIDTH-1:WIDTH];
                        mode_q <= uio_in[MODE_BIT];
                        cnt    <= '0;
                        cy     <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= {bit_d, r_sr[WIDTH-1:1]};
                    cy   <= bit_c;
                    cnt  <= cnt + 1'b1;
                    // Last bit: publish the fully shifted word, not the stale r_sr
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result <= {bit_d, r_sr[WIDTH-1:1]};
                        flag   <= bit_c;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = {1'b0, done, busy, flag, result};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
